// File: rtl/nf10_meta_pkg.sv
// Shared definitions for the NetFPGA metadata stamper: tuser field layout,
// packet length width, write FSM states and the saturating length adder.
package nf10_meta_pkg;

  localparam int LEN_W   = 16;
  localparam int LEN_LSB = 0;
  localparam int SRC_LSB = 16;
  localparam int DST_LSB = 24;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  // Packet length sticks at all-ones instead of wrapping on jumbo frames.
  function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                   input logic [LEN_W-1:0] b);
    logic [LEN_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/nf10_meta_popcount.sv
// Counts set strobe bits of one beat; feeds the packet length accumulator.
module nf10_meta_popcount #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  strb,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(strb[i]);
    end
  end

endmodule

// File: rtl/nf10_axis_meta_stamper.sv
// Store-and-forward AXI4-Stream stage stamping length/src/dst metadata into tuser.
// Optional statistics counters are enabled with `define NF10_META_STATS_EN.
//
// write FSM state | meaning
// W_IDLE          | waiting for the first beat of a packet
// W_PKT           | storing the beats of an accepted packet
// W_DROP          | discarding the remainder of a packet that did not fit
module nf10_axis_meta_stamper
  import nf10_meta_pkg::*;
#(
  parameter int         C_DATA_WIDTH  = 256,
  parameter int         C_TUSER_WIDTH = 128,
  parameter int         C_FIFO_DEPTH  = 64,
  parameter int         C_META_DEPTH  = 16,
  parameter logic [7:0] C_SRC_PORT    = 8'h01,
  parameter logic [7:0] C_DST_PORT    = 8'h00
) (
  input  logic                      axi_aclk,
  input  logic                      axi_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
`ifdef NF10_META_STATS_EN
  ,
  output logic [31:0]               stat_pkt_cnt,
  output logic [31:0]               stat_drop_cnt
`endif
);

  localparam int SW = C_DATA_WIDTH / 8;
  localparam int CW = $clog2(SW + 1);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int MW = $clog2(C_META_DEPTH);
  localparam int EW = 1 + SW + C_DATA_WIDTH;

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(C_FIFO_DEPTH);
  localparam logic [MW:0] META_ONE  = (MW+1)'(1);
  localparam logic [MW:0] META_FULL = (MW+1)'(C_META_DEPTH);

  logic [EW-1:0]    dmem [C_FIFO_DEPTH];
  logic [LEN_W-1:0] mmem [C_META_DEPTH];

  wr_state_t        wr_state, wr_next;
  logic [AW:0]      wr_ptr, wr_commit, rd_ptr;
  logic [MW:0]      mw_ptr, mr_ptr, mr_rd;
  logic [LEN_W-1:0] len_acc, len_beat;
  logic [CW-1:0]    beat_cnt;
  logic             in_beat, data_full, meta_full;
  logic             do_store, do_commit, do_rollback, drop_evt;

  logic                     rd_avail, out_load, out_xfer, rd_first, rd_last;
  logic [EW-1:0]            rd_word;
  logic [C_TUSER_WIDTH-1:0] first_user;

  nf10_meta_popcount #(.W(SW)) u_popcount (
    .strb (s_axis_tstrb),
    .cnt  (beat_cnt)
  );

  assign in_beat   = s_axis_tvalid & s_axis_tready;
  // Full is judged against the speculative pointer so oversize packets can never fit.
  assign data_full = (wr_ptr - rd_ptr) == FIFO_FULL;
  assign meta_full = (mw_ptr - mr_ptr) == META_FULL;
  assign len_beat  = (wr_state == W_IDLE) ? LEN_W'(beat_cnt)
                                          : len_sat_add(len_acc, LEN_W'(beat_cnt));

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) wr_state <= W_IDLE;
    else           wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (in_beat && !s_axis_tlast)
          wr_next = (meta_full || data_full) ? W_DROP : W_PKT;
      end
      W_PKT: begin
        if (in_beat && s_axis_tlast)   wr_next = W_IDLE;
        else if (in_beat && data_full) wr_next = W_DROP;
      end
      W_DROP: begin
        if (in_beat && s_axis_tlast) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // A dropped single-beat packet counts as a drop but never leaves W_IDLE.
  always_comb begin
    do_store    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    drop_evt    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (in_beat) begin
          if (meta_full || data_full) begin
            drop_evt = 1'b1;
          end else begin
            do_store  = 1'b1;
            do_commit = s_axis_tlast;
          end
        end
      end
      W_PKT: begin
        if (in_beat) begin
          if (data_full) begin
            do_rollback = 1'b1;
            drop_evt    = 1'b1;
          end else begin
            do_store  = 1'b1;
            do_commit = s_axis_tlast;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      mw_ptr        <= '0;
      len_acc       <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      if (do_rollback)   wr_ptr <= wr_commit;
      else if (do_store) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_commit) begin
        wr_commit <= wr_ptr + PTR_ONE;
        mw_ptr    <= mw_ptr + META_ONE;
      end
      if (do_store) len_acc <= len_beat;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (do_store)  dmem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (do_commit) mmem[mw_ptr[MW-1:0]] <= len_beat;
  end

  // mr_rd tracks the packet being read; mr_ptr frees the entry only once its tlast leaves.
  assign rd_avail = mw_ptr != mr_rd;
  assign out_load = rd_avail && (!m_axis_tvalid || m_axis_tready);
  assign out_xfer = m_axis_tvalid && m_axis_tready;
  assign rd_word  = dmem[rd_ptr[AW-1:0]];
  assign rd_last  = rd_word[EW-1];

  always_comb begin
    first_user = '0;
    first_user[LEN_LSB +: LEN_W] = mmem[mr_rd[MW-1:0]];
    first_user[SRC_LSB +: 8]     = C_SRC_PORT;
    first_user[DST_LSB +: 8]     = C_DST_PORT;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rd_ptr        <= '0;
      mr_rd         <= '0;
      mr_ptr        <= '0;
      rd_first      <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (out_load) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rd_word[C_DATA_WIDTH-1:0];
        m_axis_tstrb  <= rd_word[C_DATA_WIDTH +: SW];
        m_axis_tlast  <= rd_last;
        m_axis_tuser  <= rd_first ? first_user : '0;
        rd_first      <= rd_last;
        if (rd_last) mr_rd <= mr_rd + META_ONE;
      end else if (out_xfer) begin
        m_axis_tvalid <= 1'b0;
      end
      if (out_xfer && m_axis_tlast) mr_ptr <= mr_ptr + META_ONE;
    end
  end

`ifdef NF10_META_STATS_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      stat_pkt_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (out_xfer && m_axis_tlast) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (drop_evt)                 stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = drop_evt;
`endif

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

endmodule

// File: tb/tb_nf10_axis_meta_stamper.sv
// Self-checking bench for nf10_axis_meta_stamper: a packet-level reference model
// predicts every output beat; a second instance uses a 4-beat data buffer.
module tb_nf10_axis_meta_stamper;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic          l;
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic [UW-1:0] s_user = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, sel_b = 1'b0, m_ready = 1'b1;
  logic          a_s_valid, b_s_valid;

  logic          a_tready, a_mvalid, a_mlast, b_tready, b_mvalid, b_mlast;
  logic [DW-1:0] a_mdata, b_mdata;
  logic [SW-1:0] a_mstrb, b_mstrb;
  logic [UW-1:0] a_muser, b_muser;
`ifdef NF10_META_STATS_EN
  logic [31:0]   a_pkt, a_drop, b_pkt, b_drop;
`endif

  assign a_s_valid = s_valid & ~sel_b;
  assign b_s_valid = s_valid & sel_b;

  nf10_axis_meta_stamper dut_a (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_data), .s_axis_tstrb(s_strb), .s_axis_tuser(s_user),
    .s_axis_tvalid(a_s_valid), .s_axis_tready(a_tready), .s_axis_tlast(s_last),
    .m_axis_tdata(a_mdata), .m_axis_tstrb(a_mstrb), .m_axis_tuser(a_muser),
    .m_axis_tvalid(a_mvalid), .m_axis_tready(m_ready), .m_axis_tlast(a_mlast)
`ifdef NF10_META_STATS_EN
    , .stat_pkt_cnt(a_pkt), .stat_drop_cnt(a_drop)
`endif
  );

  nf10_axis_meta_stamper #(.C_FIFO_DEPTH(4)) dut_b (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_data), .s_axis_tstrb(s_strb), .s_axis_tuser(s_user),
    .s_axis_tvalid(b_s_valid), .s_axis_tready(b_tready), .s_axis_tlast(s_last),
    .m_axis_tdata(b_mdata), .m_axis_tstrb(b_mstrb), .m_axis_tuser(b_muser),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(m_ready), .m_axis_tlast(b_mlast)
`ifdef NF10_META_STATS_EN
    , .stat_pkt_cnt(b_pkt), .stat_drop_cnt(b_drop)
`endif
  );

  int    checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  beat_t qa[$], qb[$], expa[$], expb[$], pkt[$];
  beat_t ba, bb;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake seen at the falling edge completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && a_mvalid && m_ready) begin
      ba = {a_mlast, a_muser, a_mstrb, a_mdata};
      qa.push_back(ba);
    end
    if (!rst && b_mvalid && m_ready) begin
      bb = {b_mlast, b_muser, b_mstrb, b_mdata};
      qb.push_back(bb);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [UW-1:0] meta_user(input int len);
    logic [UW-1:0] u;
    u = '0;
    u[15:0]  = len[15:0];
    u[23:16] = 8'h01;
    u[31:24] = 8'h00;
    return u;
  endfunction

  task automatic build_pkt(input int nbeats, input int last_bytes, input bit rand_strb);
    beat_t b;
    logic [32:0] m;
    pkt.delete();
    m = (33'd1 << last_bytes) - 33'd1;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) b.u[w*32 +: 32] = $urandom;
      b.l = (i == nbeats - 1);
      if (rand_strb)   b.s = $urandom;
      else if (b.l)    b.s = m[31:0];
      else             b.s = '1;
      pkt.push_back(b);
    end
  endtask

  // Whole-packet prediction: length is the total count of valid strobe bits.
  task automatic push_expected(input bit to_b);
    int    len;
    beat_t e;
    len = 0;
    foreach (pkt[i]) len += $countones(pkt[i].s);
    if (len > 65535) len = 65535;
    foreach (pkt[i]) begin
      e   = pkt[i];
      e.u = (i == 0) ? meta_user(len) : '0;
      if (to_b) expb.push_back(e);
      else      expa.push_back(e);
    end
  endtask

  task automatic send_pkt(input int gap);
    foreach (pkt[i]) begin
      s_valid = 1'b1;
      s_data  = pkt[i].d;
      s_strb  = pkt[i].s;
      s_user  = pkt[i].u;
      s_last  = pkt[i].l;
      if (pkt[i].l) last_cyc = cyc;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    checks++;
    if (a_tready !== 1'b0) begin
      errors++; $display("FAIL reset_tready: got %b want 0", a_tready);
    end
    checks++;
    if ({a_mvalid, a_mlast, a_mdata, a_mstrb, a_muser} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b last=%b data=%h want all zero", a_mvalid, a_mlast, a_mdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_tready !== 1'b1) begin
      errors++; $display("FAIL release_tready: got %b want 1", a_tready);
    end
`ifdef NF10_META_STATS_EN
    checks++;
    if ({a_pkt, a_drop} !== 64'd0) begin
      errors++; $display("FAIL reset_stats: pkt=%0d drop=%0d want 0 0", a_pkt, a_drop);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int first;
    bit seen;
    qa.delete(); expa.delete();
    m_ready = 1'b1;
    build_pkt(2, 32, 0);
    push_expected(0);
    send_pkt(0);
    seen = 0; first = -1;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (a_mvalid) begin seen = 1; first = cyc; end
    end
    checks++;
    if (!seen || first != last_cyc + 2) begin
      errors++; $display("FAIL basic_latency: first valid cycle %0d want %0d", first, last_cyc + 2);
    end
    wait_cycles(10);
    checks++;
    if (qa.size() != expa.size()) begin
      errors++; $display("FAIL basic_count: got %0d beats want %0d", qa.size(), expa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL basic_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
    if (qa.size() > 0) begin
      checks++;
      if (qa[0].u[31:0] !== 32'h0001_0040) begin
        errors++; $display("FAIL basic_tuser: got %h want 00010040", qa[0].u[31:0]);
      end
    end
  endtask

  task automatic test_partial();
    qa.delete(); expa.delete();
    build_pkt(2, 29, 0);
    push_expected(0);
    send_pkt(0);
    wait_cycles(10);
    checks++;
    if (qa.size() != 2) begin
      errors++; $display("FAIL partial_count: got %0d beats want 2", qa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL partial_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
    if (qa.size() == 2) begin
      checks++;
      if (qa[0].u[15:0] !== 16'd61 || qa[1].s !== 32'h1FFF_FFFF) begin
        errors++; $display("FAIL partial_len: len %0d strb %h want 61 1fffffff", qa[0].u[15:0], qa[1].s);
      end
    end
  endtask

  task automatic test_drop();
    qb.delete(); expb.delete();
    sel_b = 1'b1;
    build_pkt(6, 32, 0);
    send_pkt(0);
    build_pkt(2, 17, 0);
    push_expected(1);
    send_pkt(0);
    sel_b = 1'b0;
    wait_cycles(10);
    checks++;
    if (qb.size() != expb.size()) begin
      errors++; $display("FAIL drop_count: got %0d beats want %0d", qb.size(), expb.size());
    end
    foreach (expb[i]) if (i < qb.size()) begin
      checks++;
      if (qb[i] !== expb[i]) begin
        errors++; $display("FAIL drop_beat%0d: got %h want %h", i, qb[i], expb[i]);
      end
    end
`ifdef NF10_META_STATS_EN
    checks++;
    if (b_drop !== 32'd1 || b_pkt !== 32'd1) begin
      errors++; $display("FAIL drop_stats: drop=%0d pkt=%0d want 1 1", b_drop, b_pkt);
    end
`endif
  endtask

  task automatic test_meta_full();
    qa.delete(); expa.delete();
    m_ready = 1'b0;
    for (int p = 0; p < 17; p++) begin
      build_pkt(1, $urandom_range(32, 1), 0);
      if (p < 16) push_expected(0);
      send_pkt(0);
    end
    wait_cycles(4);
    checks++;
    if (qa.size() != 0) begin
      errors++; $display("FAIL meta_stalled: got %0d beats while stalled want 0", qa.size());
    end
    m_ready = 1'b1;
    wait_cycles(40);
    checks++;
    if (qa.size() != 16) begin
      errors++; $display("FAIL meta_count: got %0d beats want 16", qa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL meta_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
`ifdef NF10_META_STATS_EN
    checks++;
    if (a_drop !== 32'd1) begin
      errors++; $display("FAIL meta_drop_stat: got %0d want 1", a_drop);
    end
`endif
  endtask

  task automatic test_stall();
    bit    stalled;
    beat_t held;
    qa.delete(); expa.delete();
    build_pkt(4, 32, 0);
    push_expected(0);
    stalled = 0;
    fork
      send_pkt(0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (stalled) begin
          checks++;
          if (!a_mvalid || {a_mlast, a_muser, a_mstrb, a_mdata} !== held) begin
            errors++; $display("FAIL stall_hold cycle %0d: valid=%b got %h want %h", c, a_mvalid, {a_mlast, a_muser, a_mstrb, a_mdata}, held);
          end
        end
        stalled = a_mvalid && !m_ready;
        held    = {a_mlast, a_muser, a_mstrb, a_mdata};
        @(posedge clk); #1;
        m_ready = ~m_ready;
      end
    join
    m_ready = 1'b1;
    wait_cycles(5);
    checks++;
    if (qa.size() != 4) begin
      errors++; $display("FAIL stall_count: got %0d beats want 4", qa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL stall_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int total, run;
    bool_loop: begin end
    qa.delete(); expa.delete();
    m_ready = 1'b0;
    total = 0;
    for (int p = 0; p < 3; p++) begin
      build_pkt(2 + p, $urandom_range(32, 1), 0);
      push_expected(0);
      total += 2 + p;
      send_pkt(0);
    end
    wait_cycles(3);
    m_ready = 1'b1;
    run = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_mvalid && run == c) run++;
    end
    checks++;
    if (run != total) begin
      errors++; $display("FAIL b2b_run: %0d consecutive valid cycles want %0d", run, total);
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    qa.delete(); expa.delete();
    fork
      for (int p = 0; p < 12; p++) begin
        build_pkt($urandom_range(6, 1), 32, 1);
        push_expected(0);
        send_pkt($urandom_range(3, 1));
      end
      begin
        for (int c = 0; c < 200; c++) begin
          m_ready = ($urandom_range(3, 0) != 0);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_cycles(100);
    checks++;
    if (qa.size() != expa.size()) begin
      errors++; $display("FAIL random_count: got %0d beats want %0d", qa.size(), expa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL random_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    qa.delete(); expa.delete();
    m_ready = 1'b0;
    build_pkt(1, 32, 0);
    send_pkt(2);
    build_pkt(4, 32, 0);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = pkt[i].d;
      s_strb  = pkt[i].s;
      s_last  = pkt[i].l;
      if (i == 1) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_tready, a_mvalid, a_mlast, a_mdata, a_mstrb, a_muser} !== '0) begin
      errors++; $display("FAIL midreset_outputs: tready=%b valid=%b last=%b data=%h want all zero", a_tready, a_mvalid, a_mlast, a_mdata);
    end
    @(posedge clk); #1;
    wait_cycles(2);
    m_ready = 1'b1;
    build_pkt(3, 9, 0);
    push_expected(0);
    send_pkt(0);
    wait_cycles(10);
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL midreset_count: got %0d beats want 3", qa.size());
    end
    foreach (expa[i]) if (i < qa.size()) begin
      checks++;
      if (qa[i] !== expa[i]) begin
        errors++; $display("FAIL midreset_beat%0d: got %h want %h", i, qa[i], expa[i]);
      end
    end
`ifdef NF10_META_STATS_EN
    checks++;
    if (a_pkt !== 32'd1) begin
      errors++; $display("FAIL midreset_pkt_stat: got %0d want 1", a_pkt);
    end
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_partial();
    test_drop();
    test_meta_full();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
